// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with a 2-entry skid buffer.
// Holds the decoded instruction bundle and hands it to execute over valid/ready.
// in_ready is registered, so there is no combinational path from out_ready to in_ready.
// The stall counter tracks cycles where execute is holding off a presented bundle.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [3:0]        in_alu_op,
   input  logic [5:0]        in_funct,
   input  logic [4:0]        in_shamt,
   input  logic [4:0]        in_rd,
   input  logic [DATA_W-1:0] in_rs_val,
   input  logic [DATA_W-1:0] in_rt_val,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_op,
   output logic [3:0]        out_alu_op,
   output logic [5:0]        out_funct,
   output logic [4:0]        out_shamt,
   output logic [4:0]        out_rd,
   output logic [DATA_W-1:0] out_rs_val,
   output logic [DATA_W-1:0] out_rt_val,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_pc,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Whole bundle is carried as one flat vector: 6+4+6+5+5 control bits plus four data words.
   localparam int PW = 26 + 4 * DATA_W;

   // Encoding is {skid_v, main_v}, so the valid bits fall straight out of the state.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } stateT;

   stateT                r_state;
   stateT                w_nextState;
   logic                 r_inReady;
   logic [PW-1:0]        r_main;
   logic [PW-1:0]        r_skid;
   logic [CNT_W-1:0]     r_stallCnt;
   logic [PW-1:0]        w_inBundle;
   logic                 w_mainV;
   logic                 w_inFire;
   logic                 w_outFire;
   logic                 w_loadMainIn;
   logic                 w_loadMainSkid;
   logic                 w_loadSkid;

   assign w_inBundle = {in_op, in_alu_op, in_funct, in_shamt, in_rd,
                        in_rs_val, in_rt_val, in_imm, in_pc};
   assign w_mainV    = r_state[0];
   assign w_inFire   = in_valid & r_inReady;
   assign w_outFire  = w_mainV & out_ready;

   assign in_ready   = r_inReady;
   assign out_valid  = w_mainV;
   assign stall_cnt  = r_stallCnt;
   assign {out_op, out_alu_op, out_funct, out_shamt, out_rd,
           out_rs_val, out_rt_val, out_imm, out_pc} = r_main;

   // State register plus the registered in_ready, which looks ahead at the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= EMPTY;
         r_inReady <= 1'b1;
      end else begin
         r_state   <= w_nextState;
         r_inReady <= (w_nextState != SKID);
      end
   end

   // Next-state and payload-enable decode; flush wins and suppresses every load.
   always_comb begin
      w_nextState    = r_state;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;
      if (flush) begin
         w_nextState = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_inFire) begin
                  w_nextState  = FULL;
                  w_loadMainIn = 1'b1;
               end
            end
            FULL: begin
               if (w_inFire && w_outFire) begin
                  w_loadMainIn = 1'b1;
               end else if (w_inFire) begin
                  w_nextState = SKID;
                  w_loadSkid  = 1'b1;
               end else if (w_outFire) begin
                  w_nextState = EMPTY;
               end
            end
            SKID: begin
               if (w_outFire) begin
                  w_nextState    = FULL;
                  w_loadMainSkid = 1'b1;
               end
            end
            default: begin
               w_nextState = EMPTY;
            end
         endcase
      end
   end

   // Payload registers move only on their enables so out_* stays put while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_loadMainIn) begin
            r_main <= w_inBundle;
         end else if (w_loadMainSkid) begin
            r_main <= r_skid;
         end
         if (w_loadSkid) begin
            r_skid <= w_inBundle;
         end
      end
   end

   // Saturating count of cycles where a bundle is offered but execute holds it off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= '0;
      end else if (w_mainV && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
         r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
